// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: assembles A, B and opcode from RX bytes, drives the ALU, streams the result to TX
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_rx_empty, i_r_data  RX FIFO status and head byte (first-word fall-through)
//   o_rd_uart             RX pop strobe (combinational)
//   i_tx_full, o_wr_uart  TX FIFO full flag and push strobe (combinational)
//   o_w_data              TX byte (registered)
//   o_a, o_b, o_op        ALU operands and opcode (registered, loaded together)
//   i_w                   ALU result
//   o_busy                frame in progress
//   o_done, o_frame_err   one-cycle completion and timeout-abort pulses
module uart_alu_bridge #(
   parameter int DATA_W      = 16,
   parameter int OP_W        = 6,
   parameter int ALU_LAT     = 1,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_rx_empty,
   input  logic [7:0]               i_r_data,
   output logic                     o_rd_uart,
   input  logic                     i_tx_full,
   output logic                     o_wr_uart,
   output logic [7:0]               o_w_data,
   output logic signed [DATA_W-1:0] o_a,
   output logic signed [DATA_W-1:0] o_b,
   output logic [OP_W-1:0]          o_op,
   input  logic signed [DATA_W-1:0] i_w,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_frame_err
);
   localparam int NB = DATA_W / 8;
   localparam int CW = NB > 1 ? $clog2(NB) : 1;
   localparam int LW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
   localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

   state_t                     r_state, w_next;
   logic [CW-1:0]              r_cnt, w_cnt_next;
   logic [LW-1:0]              r_lat;
   logic [TW-1:0]              r_to;
   logic [DATA_W-1:0]          r_sa, r_sb, r_tx;
   logic signed [DATA_W-1:0]   r_a, r_b;
   logic [OP_W-1:0]            r_op;
   logic [7:0]                 r_w_data;
   logic                       r_done, r_frame_err;
   logic                       w_intake, w_acc, w_push, w_to_act, w_expire, w_cnt_last, w_lat_last;

   always_comb begin
      w_intake   = (r_state == GET_A) | (r_state == GET_B) | (r_state == GET_OP);
      w_acc      = ~i_reset & w_intake & ~i_rx_empty;
      w_push     = ~i_reset & (r_state == SEND) & ~i_tx_full;
      w_cnt_last = r_cnt == CNT_LAST;
      w_lat_last = r_lat == LAT_LAST;
      // idle GET_A with no partial operand is not inside a frame, so it never times out
      w_to_act   = (TIMEOUT_CYC != 0) & ((r_state == GET_B) | (r_state == GET_OP) |
                   ((r_state == GET_A) & (r_cnt != '0)));
      // a byte arriving on the expiry cycle wins over the abort
      w_expire   = w_to_act & ~w_acc & (r_to == TO_LAST);
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         GET_A: begin
            if (w_expire) w_cnt_next = '0;
            else if (w_acc) begin
               w_cnt_next = w_cnt_last ? '0 : r_cnt + 1'b1;
               w_next     = w_cnt_last ? GET_B : GET_A;
            end
         end
         GET_B: begin
            if (w_expire) begin
               w_next     = GET_A;
               w_cnt_next = '0;
            end else if (w_acc) begin
               w_cnt_next = w_cnt_last ? '0 : r_cnt + 1'b1;
               w_next     = w_cnt_last ? GET_OP : GET_B;
            end
         end
         GET_OP: w_next = w_expire ? GET_A : (w_acc ? EXEC : GET_OP);
         EXEC:   w_next = w_lat_last ? SEND : EXEC;
         SEND: begin
            if (w_push) begin
               w_cnt_next = w_cnt_last ? '0 : r_cnt + 1'b1;
               w_next     = w_cnt_last ? GET_A : SEND;
            end
         end
         default: w_next = GET_A;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= GET_A;
         r_cnt       <= '0;
         r_lat       <= '0;
         r_to        <= '0;
         r_sa        <= '0;
         r_sb        <= '0;
         r_tx        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_w_data    <= '0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_next;
         r_lat       <= (r_state == EXEC && !w_lat_last) ? r_lat + 1'b1 : '0;
         r_to        <= (w_to_act && !w_acc && !w_expire) ? r_to + 1'b1 : '0;
         r_done      <= w_push & w_cnt_last;
         r_frame_err <= w_expire;
         for (int i = 0; i < NB; i++) begin
            if (r_state == GET_A && w_acc && r_cnt == CW'(i)) r_sa[i*8 +: 8] <= i_r_data;
            if (r_state == GET_B && w_acc && r_cnt == CW'(i)) r_sb[i*8 +: 8] <= i_r_data;
         end
         // operands and opcode change on one edge so the ALU never sees a mixed set
         if (r_state == GET_OP && w_acc) begin
            r_a  <= r_sa;
            r_b  <= r_sb;
            r_op <= i_r_data[OP_W-1:0];
         end
         if (r_state == EXEC && w_lat_last) begin
            r_tx     <= i_w;
            r_w_data <= i_w[7:0];
         end
         if (w_push) begin
            r_tx     <= r_tx >> 8;
            r_w_data <= 8'(r_tx >> 8);
         end
      end
   end

   assign o_rd_uart   = w_acc;
   assign o_wr_uart   = w_push;
   assign o_w_data    = r_w_data;
   assign o_a         = r_a;
   assign o_b         = r_b;
   assign o_op        = r_op;
   assign o_done      = r_done;
   assign o_frame_err = r_frame_err;
   assign o_busy      = ~i_reset & ((r_state != GET_A) | (r_cnt != '0));
endmodule

// File: doc/uart_alu_bridge.md
Name: uart_alu_bridge

Overview:
UART-to-ALU command bridge for multi-byte operands. It assembles operands A and B and an opcode byte from the UART RX FIFO, presents them to the ALU together, and waits a fixed ALU latency. It then streams the DATA_W-bit result back through the UART TX FIFO. Adds inter-byte timeout/abort and completion and error status pulses.

Parameters:
DATA_W, 16, operand/result width in bits; must be a multiple of 8; NB = DATA_W/8 bytes per operand/result.
OP_W, 6, opcode width (≤8); taken from r_data[OP_W-1:0].
ALU_LAT, 1, cycles (≥1) between operand update and result capture.
TIMEOUT_CYC, 100000, max idle cycles between bytes of one frame; 0 disables the timeout.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_empty  in  1  RX FIFO empty; r_data valid when low (first-word fall-through)
r_data  in  8  RX FIFO head byte
rd_uart  out  1  RX pop strobe, combinational
tx_full  in  1  TX FIFO full
wr_uart  out  1  TX push strobe, combinational
w_data  out  8  TX byte, registered
a  out  DATA_W  operand A, signed, registered
b  out  DATA_W  operand B, signed, registered
op  out  OP_W  opcode, registered
w  in  DATA_W  ALU result, signed
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last result byte is pushed
frame_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (sync, wins over everything): state=GET_A; byte counter=0; timeout counter=0. Registered outputs clear: a=0, b=0, op=0, w_data=0, done=0, frame_err=0. rd_uart=0, wr_uart=0, busy=0.
- States: GET_A, GET_B, GET_OP, EXEC, SEND.
- Byte intake (GET_A/GET_B/GET_OP only):
  - rd_uart = ~rx_empty, combinational.
  - Byte captured on the same edge as the pop.
  - rd_uart=0 in EXEC and SEND, regardless of rx_empty.
- Byte order and assembly:
  - A and B arrive LSB first, NB bytes each, into shadow registers.
  - Byte counter selects the byte lane and wraps to 0 at NB-1 with a state advance: GET_A→GET_B→GET_OP.
  - GET_OP takes exactly 1 byte, then goes to EXEC.
  - On the GET_OP accept edge, a, b and op load simultaneously from shadow/r_data. The ALU never sees partial operands.
- EXEC: counts ALU_LAT cycles from the operand update. On the final cycle, w is latched into the TX shift register, w_data = w[7:0], and the state moves to SEND.
- SEND:
  - wr_uart = ~tx_full, combinational.
  - On each push, shift right 8 and update w_data to the next byte; byte counter increments.
  - Push with counter=NB-1: go to GET_A, done=1 for one cycle.
  - tx_full high: no push; w_data and counter hold, indefinitely.
- Timeout:
  - Counter active when state is GET_B or GET_OP, or GET_A with byte counter>0.
  - Counter clears on every accepted byte and increments on cycles with no accepted byte.
  - On reaching TIMEOUT_CYC: go to GET_A, clear byte counter, frame_err=1 for one cycle. a/b/op keep their previous values.
  - A byte accepted in the same cycle the counter would expire is accepted: no error, counter clears.
  - Not active in EXEC/SEND or in idle GET_A with counter 0.
- busy = (state==EXEC) | (state==SEND) | (byte counter≠0) | (state==GET_B) | (state==GET_OP).
- Back-to-back: one byte per cycle is accepted when rx_empty stays low. Minimum frame time is 2·NB+1 intake cycles + ALU_LAT + NB push cycles.

Test Plan:
1. DATA_W=16, rx bytes 34,12,FE,FF,20 with ALU w=1232 → a=0x1234, b=0xFFFE (−2), op=0x20 all update on the same edge after the 5th byte. TX pushes 0x32 then 0x12; done pulses once; busy falls with done.
2. rx_empty held low with all 5 bytes queued → rd_uart high 5 consecutive cycles, then low through EXEC/SEND despite extra queued bytes. The 6th byte is popped only after done.
3. tx_full high for 10 cycles on entering SEND → wr_uart=0, w_data=0x32 stable. On release, 0x32 and 0x12 are pushed on consecutive cycles.
4. TIMEOUT_CYC=100, one byte then 100 idle cycles → frame_err pulse, state GET_A, a/b/op unchanged. A following full 5-byte frame completes normally.
5. Byte delivered exactly on the expiry cycle → accepted, no frame_err, frame continues.
6. reset asserted in SEND after the first push → next cycle all outputs 0 and no further wr_uart. A fresh frame afterwards produces the correct result bytes.
